// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor drive path (duty width, ramp FSM states).
package motor_pkg;

    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        SWAP  = 2'd2
    } ramp_state_e;

    // One LSB toward tgt, or hold when already there.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + duty_t'(1);
        end else if (cur > tgt) begin
            res = cur - duty_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Soft-start, slew-limited duty controller with sequenced direction reversal
// (ramp to zero, swap direction, ramp back up) feeding motor_drv.
module duty_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int CLK_HZ       = 25000000,
    parameter int RAMP_HZ      = 1000,
    parameter int STEP         = 8,
    parameter int DUTY_MIN     = 8,
    parameter int DUTY_MAX     = 248,
    parameter int DUTY_DEFAULT = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              preset,
    input  logic              dir_req,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              direction,
    output logic              at_target,
    output logic              reversing
);

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] MIN_X  = (DUTY_W + 1)'(DUTY_MIN);
    localparam logic [DUTY_W:0] MAX_X  = (DUTY_W + 1)'(DUTY_MAX);

    logic            tick;
    ramp_state_e     state_q;
    duty_t           duty_q;
    duty_t           target_q;
    duty_t           target_d;
    logic            dir_q;
    logic            at_target_q;
    logic            reversing_q;
    logic [DUTY_W:0] inc_sum;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(RAMP_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Widened by one bit so clamping never sees a wrapped value.
    assign inc_sum = {1'b0, target_q} + STEP_X;

    always_comb begin
        target_d = target_q;
        if (preset) begin
            target_d = duty_t'(DUTY_DEFAULT);
        end else if (inc && dec) begin
            target_d = target_q;
        end else if (inc) begin
            target_d = (inc_sum > MAX_X) ? duty_t'(DUTY_MAX) : inc_sum[DUTY_W-1:0];
        end else if (dec) begin
            target_d = ({1'b0, target_q} < (MIN_X + STEP_X)) ? duty_t'(DUTY_MIN)
                                                            : target_q - duty_t'(STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            target_q    <= duty_t'(DUTY_DEFAULT);
            at_target_q <= 1'b0;
            reversing_q <= 1'b0;
        end else begin
            target_q    <= target_d;
            at_target_q <= (state_q == RUN) && (duty_q == target_q);
            case (state_q)
                RUN: begin
                    if (dir_req != dir_q) begin
                        state_q     <= BRAKE;
                        reversing_q <= 1'b1;
                    end else if (tick) begin
                        duty_q <= step_toward(duty_q, target_q);
                    end
                end
                BRAKE: begin
                    // Abort takes precedence: the operator changed their mind.
                    if (dir_req == dir_q) begin
                        state_q     <= RUN;
                        reversing_q <= 1'b0;
                    end else if (duty_q == '0) begin
                        state_q <= SWAP;
                    end else if (tick) begin
                        duty_q <= duty_q - duty_t'(1);
                    end
                end
                SWAP: begin
                    dir_q       <= dir_req;
                    state_q     <= RUN;
                    reversing_q <= 1'b0;
                end
                default: begin
                    state_q     <= RUN;
                    reversing_q <= 1'b0;
                end
            endcase
        end
    end

    assign duty_cycle = duty_q;
    assign direction  = dir_q;
    assign at_target  = at_target_q;
    assign reversing  = reversing_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl: directed scenarios plus random pulses,
// every cycle compared against a behavioural model of the ramp/reversal rules.
module tb_duty_ramp_ctrl;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc;
    logic       dec;
    logic       preset;
    logic       dir_req;
    logic [7:0] duty_cycle;
    logic       direction;
    logic       at_target;
    logic       reversing;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: mode 0 = running, 1 = braking toward zero, 2 = swapping.
    int m_target;
    int m_duty;
    int m_dir;
    int m_mode;
    int m_cnt;
    int m_at;
    int m_rev;

    always #5 clk = ~clk;

    duty_ramp_ctrl #(
        .CLK_HZ      (100),
        .RAMP_HZ     (10),
        .STEP        (8),
        .DUTY_MIN    (8),
        .DUTY_MAX    (248),
        .DUTY_DEFAULT(128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc),
        .dec       (dec),
        .preset    (preset),
        .dir_req   (dir_req),
        .duty_cycle(duty_cycle),
        .direction (direction),
        .at_target (at_target),
        .reversing (reversing)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Next-state of the behavioural model for the inputs present at this edge.
    task automatic model_step();
        bit is_tick;
        int nt;
        if (rst) begin
            m_target = 128; m_duty = 0; m_dir = 0; m_mode = 0;
            m_cnt = 0; m_at = 0; m_rev = 0;
            return;
        end
        is_tick = (m_cnt == DIV - 1);
        m_cnt   = (m_cnt + 1) % DIV;
        nt      = m_target;
        if (preset)           nt = 128;
        else if (inc && !dec) nt = (m_target + 8 > 248) ? 248 : m_target + 8;
        else if (dec && !inc) nt = (m_target - 8 < 8) ? 8 : m_target - 8;
        m_at = (m_mode == 0 && m_duty == m_target) ? 1 : 0;
        case (m_mode)
            0: begin
                if (dir_req != m_dir) m_mode = 1;
                else if (is_tick && m_duty < m_target) m_duty++;
                else if (is_tick && m_duty > m_target) m_duty--;
            end
            1: begin
                if (dir_req == m_dir) m_mode = 0;
                else if (m_duty == 0) m_mode = 2;
                else if (is_tick) m_duty--;
            end
            default: begin
                m_dir  = dir_req;
                m_mode = 0;
            end
        endcase
        m_rev    = (m_mode != 0) ? 1 : 0;
        m_target = nt;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("duty", duty_cycle, m_duty);
        check_eq("direction", direction, m_dir);
        check_eq("at_target", at_target, m_at);
        check_eq("reversing", reversing, m_rev);
        check_eq("target", dut.target_q, m_target);
        check_eq("duty_le_max", (duty_cycle <= 8'd248) ? 1 : 0, 1);
    endtask

    task automatic wait_duty(input int val, input int max_cyc, input string tag);
        int n = 0;
        while (duty_cycle != val[7:0] && n < max_cyc) begin
            cycle();
            n++;
        end
        if (duty_cycle != val[7:0]) check_eq(tag, duty_cycle, val);
    endtask

    initial begin
        rst = 1'b1; inc = 1'b0; dec = 1'b0; preset = 1'b0; dir_req = 1'b0;
        repeat (3) cycle();
        check_eq("rst_duty", duty_cycle, 0);
        check_eq("rst_target", dut.target_q, 128);
        rst = 1'b0;

        // Soft start: nothing moves until the first tick, then 1 LSB per DIV.
        for (int i = 1; i <= 9; i++) begin
            cycle();
            check_eq("soft_start_hold", duty_cycle, 0);
        end
        cycle();
        check_eq("first_step_cycle10", duty_cycle, 1);
        repeat (1300) cycle();
        check_eq("soft_start_duty", duty_cycle, 128);
        check_eq("soft_start_at_target", at_target, 1);
        $display("[TB] soft start: duty=%0d at_target=%0d", duty_cycle, at_target);

        for (int i = 1; i <= 20; i++) begin
            inc = 1'b1; cycle();
            inc = 1'b0; cycle();
            if (i == 15) check_eq("target_clamp_15", dut.target_q, 248);
        end
        repeat (1250) cycle();
        check_eq("ramp_to_max", duty_cycle, 248);
        $display("[TB] 20 inc pulses: target=%0d duty=%0d", dut.target_q, duty_cycle);

        for (int i = 1; i <= 40; i++) begin
            dec = 1'b1; cycle();
            dec = 1'b0; cycle();
        end
        check_eq("target_clamp_min", dut.target_q, 8);
        repeat (2450) cycle();
        check_eq("ramp_to_min", duty_cycle, 8);
        $display("[TB] 40 dec pulses: target=%0d duty=%0d", dut.target_q, duty_cycle);

        inc = 1'b1; dec = 1'b1; cycle();
        check_eq("inc_dec_same", dut.target_q, 8);
        dec = 1'b0; preset = 1'b1; cycle();
        check_eq("preset_over_inc", dut.target_q, 128);
        inc = 1'b0; preset = 1'b0;
        repeat (1250) cycle();
        check_eq("back_to_default", duty_cycle, 128);
        $display("[TB] inc+dec / preset+inc: target=%0d", dut.target_q);

        dir_req = 1'b1; cycle();
        check_eq("brake_entry_rev", reversing, 1);
        wait_duty(0, 1400, "wait_brake_zero");
        cycle();
        check_eq("swap_rev", reversing, 1);
        check_eq("swap_dir_old", direction, 0);
        cycle();
        check_eq("after_swap_dir", direction, 1);
        check_eq("after_swap_rev", reversing, 0);
        repeat (1300) cycle();
        check_eq("reverse_ramp_up", duty_cycle, 128);
        $display("[TB] reversal 0->1: dir=%0d duty=%0d", direction, duty_cycle);

        dir_req = 1'b0;
        repeat (2700) cycle();
        check_eq("reverse_back_dir", direction, 0);
        dir_req = 1'b1;
        wait_duty(60, 800, "wait_brake_60");
        dir_req = 1'b0; cycle();
        check_eq("abort_rev", reversing, 0);
        repeat (700) cycle();
        check_eq("abort_dir", direction, 0);
        check_eq("abort_duty", duty_cycle, 128);
        $display("[TB] brake abort at 60: dir=%0d duty=%0d", direction, duty_cycle);

        dir_req = 1'b1;
        wait_duty(50, 900, "wait_brake_50");
        rst = 1'b1; cycle();
        check_eq("midbrake_rst_duty", duty_cycle, 0);
        check_eq("midbrake_rst_dir", direction, 0);
        check_eq("midbrake_rst_target", dut.target_q, 128);
        check_eq("midbrake_rst_state", int'(dut.state_q), 0);
        check_eq("midbrake_rst_rev", reversing, 0);
        rst = 1'b0; dir_req = 1'b0;
        $display("[TB] reset mid-brake: duty=%0d dir=%0d", duty_cycle, direction);

        for (int i = 0; i < 6000; i++) begin
            inc     = ($urandom % 16) == 0;
            dec     = ($urandom % 16) == 0;
            preset  = ($urandom % 97) == 0;
            rst     = ($urandom % 1500) == 0;
            if (($urandom % 400) == 0) dir_req = ~dir_req;
            cycle();
        end
        rst = 1'b0; inc = 1'b0; dec = 1'b0; preset = 1'b0;
        $display("[TB] random phase: duty=%0d target=%0d dir=%0d", duty_cycle, dut.target_q, direction);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
